uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Serial receive front end of the console's uart-to-screen path.
- Sits between the `uartRx` pin and the VT100 escape-sequence parser inside the video controller.
- Synchronises and oversamples the line, deframes 8N1 bytes, and buffers them in a small first-word-fall-through FIFO.
- The parser drains the FIFO with a valid/ready handshake at its own pace.

Parameters:
- CLK_FREQUENCY, 100_000_000, clk frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- OVERSAMPLE, 16, sample ticks per bit; must be even and at least 8.
- FIFO_DEPTH, 16, byte entries; power of two, at least 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- uartRx  input  1  asynchronous serial line, idle high.
- rdData  output  8  byte at FIFO head.
- rdValid  output  1  FIFO non-empty.
- rdReady  input  1  consumer accepts head when rdValid is high.
- fifoCount  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- frameError  output  1  one-cycle pulse when a bad stop bit is detected.
- parityError  output  1  one-cycle pulse on a parity mismatch; tied 0 when parity is compiled out.
- overrun  output  1  sticky; set when a byte is dropped on a full FIFO; cleared only by rst.

Behaviour:
- Reset values: rdValid=0, rdData=0, fifoCount=0, frameError=0, parityError=0, overrun=0, FSM=IDLE, tick divider=0.
- Reset is synchronous: an rst asserted mid-frame abandons the frame, and the FIFO contents are discarded.
- Line synchroniser: two flip-flops, both reset to 1. The FSM sees only the synchronised bit, which adds 2 cycles of input latency.
- Tick generator: DIV = CLK_FREQUENCY/(BAUD*OVERSAMPLE), integer floor. DIV=0 is an elaboration error.
  - Emits a one-cycle tick when the counter reaches DIV-1, then wraps to 0.
  - The counter is reset to 0 on every IDLE->START transition so the start-bit phase is aligned.
- FSM states and transitions:
  - IDLE: on synchronised line = 0, go to START and clear the tick counter.
  - START: at tick OVERSAMPLE/2-1, resample.
    - Line = 1 is a glitch: return to IDLE with no error.
    - Line = 0: go to DATA with bit index 0.
  - DATA: sample every OVERSAMPLE ticks, shifting LSB first. After bit 7, go to STOP, or to PARITY when UART_PARITY_EN is defined.
  - STOP: sample after OVERSAMPLE ticks.
    - Line = 1: push the byte and go to IDLE.
    - Line = 0: pulse frameError, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until the synchronised line = 1 (break or framing recovery), then go to IDLE.
- Push timing: the push happens in the same cycle as the stop-bit sample. With the FIFO empty, rdValid rises and rdData is valid on the next clock edge.
- FIFO behaviour:
  - First-word-fall-through: rdData always reflects the head, and rdValid = (count != 0).
  - Pop occurs on any cycle with rdValid && rdReady.
  - Push while full with no simultaneous pop: the byte is dropped, overrun is set, and count stays at FIFO_DEPTH.
  - Push while full with a simultaneous pop: both are accepted, count is unchanged, and overrun is not set.
  - Push while empty with rdReady=1: the byte is not bypassed; it appears the next cycle.
  - Pointers wrap modulo FIFO_DEPTH, and the count saturates correctly at 0 and FIFO_DEPTH.
- rdData must be stable while rdValid && !rdReady.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined: a PARITY state follows DATA and samples one even-parity bit after OVERSAMPLE ticks. On a mismatch, parityError pulses for one cycle; the byte is then discarded after the STOP check, and STOP/frameError handling is unchanged.
- Undefined: the link is 8N1, no PARITY state is built, and parityError is driven constant 0.

Decomposition:
- Package UartPkg holds:
  - UART_DATA_WIDTH=8;
  - enum UartRxState_t {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE};
  - the divider-computation function.
- One sub-module, byte_fifo: a synchronous FWFT FIFO with the push/pop/full/empty/count rules above, reused later by the keyboard transmit path.

Test Plan:
All scenarios use CLK_FREQUENCY=1_600_000, BAUD=10_000, OVERSAMPLE=16, so DIV=10 and one bit = 160 clk.
1. Send 0x41 with 8N1 framing and rdReady=1 -> rdData=0x41 with rdValid high for exactly 1 cycle, about 1526 clk after the falling edge; no error pulses.
2. Send 0x00, 0xFF and 0x55 back-to-back with rdReady=0 -> fifoCount=3. Then hold rdReady=1 -> bytes pop in order 0x00, 0xFF, 0x55 on consecutive cycles and fifoCount returns to 0.
3. Send 17 bytes (0x01..0x11) with rdReady=0 and FIFO_DEPTH=16 -> fifoCount=16, overrun=1 after the 17th byte, and the contents read back as 0x01..0x10. Repeat, asserting rdReady on the cycle of the 17th push -> overrun stays 0.
4. Send 0xA5 with the stop bit forced low, holding the line low for 400 clk -> frameError pulses once, nothing is pushed, and the FSM stays in WAIT_IDLE until the line rises. A following 0x3C is received correctly.
5. Apply a 60-clk low glitch on an idle line -> no byte and no error. Assert rst mid-frame, at bit 4 of 0x7E -> all outputs take reset values and the next full byte 0x7E is received correctly.
6. With UART_PARITY_EN defined: send 0x03 with parity 0 -> byte accepted. Send 0x03 with parity 1 -> parityError pulses and no push occurs.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and the baud-divider helper for the UART receive path.
package UartPkg;
  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} UartRxState_t;

  // Clock cycles per oversample tick, floored; 0 means the line rate is unreachable.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return int'(longint'(clk_hz) / (longint'(baud) * longint'(os)));
  endfunction
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Read-side handshake between the receive FIFO and its consumer (the VT100 parser).
interface uart_rx_fifo_if #(parameter int FIFO_DEPTH = 16);
  import UartPkg::*;
  logic [UART_DATA_WIDTH-1:0]     rdData;
  logic                           rdValid;
  logic                           rdReady;
  logic [$clog2(FIFO_DEPTH):0]    fifoCount;

  modport master (output rdData, rdValid, fifoCount, input rdReady);
  modport slave  (input rdData, rdValid, fifoCount, output rdReady);
endinterface

// File: rtl/uart_rx_fifo_byte_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full only lands if a pop frees a slot the same cycle.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign valid   = (count != '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  // Empty reads as zero so the head has a defined value out of reset.
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive front end: sync, oversampled 8N1 deframer and FWFT byte FIFO.
// Define UART_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_fifo
  import UartPkg::*;
#(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD          = 115200,
  parameter int OVERSAMPLE    = 16,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           uartRx,
  uart_rx_fifo_if.master rd,
  output logic           frameError,
  output logic           parityError,
  output logic           overrun
);
  localparam int DIV = calc_div(CLK_FREQUENCY, BAUD, OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_HALF   = OW'(OVERSAMPLE / 2 - 1);

  generate
    if (DIV < 1) begin : g_bad_div
      $error("uart_rx_fifo: CLK_FREQUENCY/(BAUD*OVERSAMPLE) is zero");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
      $error("uart_rx_fifo: OVERSAMPLE must be even and >= 8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic rx_meta, rx;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
    end else begin
      rx_meta <= uartRx;
      rx      <= rx_meta;
    end
  end

  logic [TW-1:0] tick_cnt;
  logic [OW-1:0] os_cnt;
  logic          tick, tick_clr, os_clr, os_half, os_last;

  assign tick    = (tick_cnt == TICK_LAST);
  assign os_half = tick && (os_cnt == OS_HALF);
  assign os_last = tick && (os_cnt == OS_LAST);

  // Divider restarts on the start edge so sampling lands mid-bit.
  always_ff @(posedge clk) begin
    if (rst || tick_clr || tick) tick_cnt <= '0;
    else                         tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || os_clr || os_last) os_cnt <= '0;
    else if (tick)                os_cnt <= os_cnt + 1'b1;
  end

  UartRxState_t               state, state_nxt;
  logic [UART_DATA_WIDTH-1:0] shreg;
  logic [2:0]                 bit_idx;
  logic                       shift, push, frame_err, par_bad, drop;
`ifdef UART_PARITY_EN
  logic                       par_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tick_clr  = 1'b0;
    os_clr    = 1'b0;
    shift     = 1'b0;
    push      = 1'b0;
    frame_err = 1'b0;
`ifdef UART_PARITY_EN
    par_err   = 1'b0;
`endif
    case (state)
      IDLE: if (!rx) begin
        state_nxt = START;
        tick_clr  = 1'b1;
        os_clr    = 1'b1;
      end
      START: if (os_half) begin
        os_clr    = 1'b1;
        state_nxt = rx ? IDLE : DATA;
      end
      DATA: if (os_last) begin
        shift = 1'b1;
        if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      PARITY: if (os_last) begin
        par_err   = (rx != ^shreg);
        state_nxt = STOP;
      end
`endif
      STOP: if (os_last) begin
        if (rx) begin
          push      = !par_bad;
          state_nxt = IDLE;
        end else begin
          frame_err = 1'b1;
          state_nxt = WAIT_IDLE;
        end
      end
      WAIT_IDLE: if (rx) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      bit_idx    <= '0;
      frameError <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frameError <= frame_err;
      if (drop) overrun <= 1'b1;
      if (state == START) bit_idx <= '0;
      else if (shift) begin
        shreg   <= {rx, shreg[UART_DATA_WIDTH-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

`ifdef UART_PARITY_EN
  // A bad parity bit still waits for the stop check before the byte is thrown away.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad     <= 1'b0;
      parityError <= 1'b0;
    end else begin
      parityError <= par_err;
      if (state == START) par_bad <= 1'b0;
      else if (par_err)   par_bad <= 1'b1;
    end
  end
`else
  assign par_bad     = 1'b0;
  assign parityError = 1'b0;
`endif

  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(UART_DATA_WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shreg),
    .pop       (rd.rdReady),
    .head      (rd.rdData),
    .valid     (rd.rdValid),
    .count     (rd.fifoCount),
    .drop      (drop)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo at 160 clk per bit; sends a parity bit when UART_PARITY_EN is defined.
module tb_uart_rx_fifo;
  localparam int CLK_HZ  = 1_600_000;
  localparam int BAUD    = 10_000;
  localparam int OS      = 16;
  localparam int DEPTH   = 16;
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int TICK    = CLK_HZ / (BAUD * OS);
  localparam int BIT_CLK = TICK * OS;
`ifdef UART_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  // Cycle of the stop-bit sample counted from the edge that drops the line: 2 sync stages,
  // one IDLE->START edge, then half a bit to mid-start plus one full bit per later field.
  localparam int PUSH_CYC = 3 + TICK * (OS / 2 + OS * (9 + PAR_EN)) - 1;

  logic clk = 1'b0, rst = 1'b1, uartRx = 1'b1;
  logic frameError, parityError, overrun;

  uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) rd_if ();

  uart_rx_fifo #(.CLK_FREQUENCY(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .uartRx(uartRx), .rd(rd_if),
    .frameError(frameError), .parityError(parityError), .overrun(overrun));

  always #5 clk = ~clk;

  int n_run = 0, n_fail = 0;
  int w_valid, w_first, w_fe, w_pe;
  logic [7:0] w_data;

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One frame; stop_len lets a low stop bit be stretched into a break.
  task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop, input int stop_len);
    @(posedge clk); #1 uartRx = 1'b0;
    repeat (BIT_CLK) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 uartRx = b[i];
      repeat (BIT_CLK) @(posedge clk);
    end
    if (PAR_EN != 0) begin
      #1 uartRx = (^b) ^ !par_ok;
      repeat (BIT_CLK) @(posedge clk);
    end
    #1 uartRx = stop;
    repeat (stop_len) @(posedge clk);
    #1 uartRx = 1'b1;
  endtask

  // Records output activity over n cycles starting at the same edge a concurrent send_frame starts.
  task automatic watch(input int n);
    w_valid = 0; w_first = -1; w_fe = 0; w_pe = 0; w_data = '0;
    @(posedge clk);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (rd_if.rdValid) begin
        if (w_valid == 0) begin w_first = c; w_data = rd_if.rdData; end
        w_valid++;
      end
      if (frameError)  w_fe++;
      if (parityError) w_pe++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_run++; if ({rd_if.rdValid, rd_if.rdData} !== 9'h0) begin n_fail++; $display("FAIL reset_rd: got valid %0b data %0h want 0/0", rd_if.rdValid, rd_if.rdData); end
    n_run++; if (rd_if.fifoCount !== CW'(0)) begin n_fail++; $display("FAIL reset_count: got %0d want 0", rd_if.fifoCount); end
    n_run++; if ({frameError, parityError, overrun} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {frameError, parityError, overrun}); end
  endtask

  task automatic test_single();
    rd_if.rdReady = 1'b1;
    fork
      send_frame(8'h41, 1'b1, 1'b1, BIT_CLK);
      watch(1700 + PAR_EN * BIT_CLK);
    join
    n_run++; if (w_valid !== 1) begin n_fail++; $display("FAIL single_valid_cycles: got %0d want 1", w_valid); end
    n_run++; if (w_data !== 8'h41) begin n_fail++; $display("FAIL single_data: got %0h want 41", w_data); end
    n_run++; if (w_first < 1516 + PAR_EN * BIT_CLK || w_first > 1536 + PAR_EN * BIT_CLK) begin
      n_fail++; $display("FAIL single_latency: got %0d want about %0d", w_first, 1526 + PAR_EN * BIT_CLK); end
    n_run++; if (w_fe + w_pe !== 0) begin n_fail++; $display("FAIL single_errors: got %0d pulses want 0", w_fe + w_pe); end
    rd_if.rdReady = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [3] = '{8'h00, 8'hFF, 8'h55};
    rd_if.rdReady = 1'b0;
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1, 1'b1, BIT_CLK);
    repeat (4) @(negedge clk);
    n_run++; if (rd_if.fifoCount !== CW'(3)) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", rd_if.fifoCount); end
    @(posedge clk); #1 rd_if.rdReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_run++; if (!rd_if.rdValid || rd_if.rdData !== exp_b[i]) begin
        n_fail++; $display("FAIL b2b_pop%0d: got %0h valid %0b want %0h", i, rd_if.rdData, rd_if.rdValid, exp_b[i]); end
    end
    @(negedge clk);
    n_run++; if (rd_if.fifoCount !== CW'(0) || rd_if.rdValid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_empty: got count %0d valid %0b want 0/0", rd_if.fifoCount, rd_if.rdValid); end
    rd_if.rdReady = 1'b0;
  endtask

  task automatic test_overrun();
    logic [7:0] q [$];
    logic [7:0] b;
    bit ovr_m = 1'b0;
    rd_if.rdReady = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      send_frame(8'(i), 1'b1, 1'b1, BIT_CLK);
      if (q.size() < DEPTH) q.push_back(8'(i)); else ovr_m = 1'b1;
    end
    repeat (4) @(negedge clk);
    n_run++; if (rd_if.fifoCount !== CW'(q.size())) begin n_fail++; $display("FAIL ovr_count: got %0d want %0d", rd_if.fifoCount, q.size()); end
    n_run++; if (overrun !== ovr_m) begin n_fail++; $display("FAIL ovr_flag: got %0b want %0b", overrun, ovr_m); end
    @(posedge clk); #1 rd_if.rdReady = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      b = q.pop_front();
      n_run++; if (!rd_if.rdValid || rd_if.rdData !== b) begin
        n_fail++; $display("FAIL ovr_read%0d: got %0h valid %0b want %0h", i, rd_if.rdData, rd_if.rdValid, b); end
    end
    @(posedge clk); #1 rd_if.rdReady = 1'b0;

    // Refill with random bytes, then land the extra byte on the same edge as a pop.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, 1'b1, BIT_CLK);
      q.push_back(b);
    end
    b = 8'($urandom_range(0, 255));
    fork
      send_frame(b, 1'b1, 1'b1, BIT_CLK);
      begin
        @(posedge clk);
        repeat (PUSH_CYC) @(posedge clk);
        #1 rd_if.rdReady = 1'b1;
        @(posedge clk);
        #1 rd_if.rdReady = 1'b0;
      end
    join
    void'(q.pop_front());
    q.push_back(b);
    repeat (2) @(negedge clk);
    n_run++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pop_push_flag: got %0b want 0", overrun); end
    n_run++; if (rd_if.fifoCount !== CW'(DEPTH)) begin n_fail++; $display("FAIL ovr_pop_push_count: got %0d want %0d", rd_if.fifoCount, DEPTH); end
    for (int c = 0; c < 400 && q.size() > 0; c++) begin
      @(posedge clk); #1 rd_if.rdReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (rd_if.rdReady && rd_if.rdValid) begin
        b = q.pop_front();
        n_run++; if (rd_if.rdData !== b) begin n_fail++; $display("FAIL rand_drain: got %0h want %0h", rd_if.rdData, b); end
      end
    end
    @(posedge clk); #1 rd_if.rdReady = 1'b0;
    @(negedge clk);
    n_run++; if (q.size() != 0 || rd_if.fifoCount !== CW'(0)) begin
      n_fail++; $display("FAIL rand_drain_done: got %0d left, count %0d want 0/0", q.size(), rd_if.fifoCount); end
  endtask

  task automatic test_frame_error();
    rd_if.rdReady = 1'b0;
    fork
      send_frame(8'hA5, 1'b1, 1'b0, 400);
      watch(3300 + PAR_EN * BIT_CLK);
    join
    n_run++; if (w_fe !== 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d want 1", w_fe); end
    n_run++; if (w_valid !== 0 || rd_if.fifoCount !== CW'(0)) begin
      n_fail++; $display("FAIL ferr_nopush: got %0d valid cycles count %0d want 0/0", w_valid, rd_if.fifoCount); end
    send_frame(8'h3C, 1'b1, 1'b1, BIT_CLK);
    repeat (3) @(negedge clk);
    n_run++; if (rd_if.fifoCount !== CW'(1) || rd_if.rdData !== 8'h3C) begin
      n_fail++; $display("FAIL ferr_recover: got count %0d data %0h want 1/3c", rd_if.fifoCount, rd_if.rdData); end
    @(posedge clk); #1 rd_if.rdReady = 1'b1;
    @(posedge clk); #1 rd_if.rdReady = 1'b0;
  endtask

  task automatic test_glitch_and_reset();
    rd_if.rdReady = 1'b0;
    fork
      begin @(posedge clk); #1 uartRx = 1'b0; repeat (60) @(posedge clk); #1 uartRx = 1'b1; end
      watch(400);
    join
    n_run++; if (w_valid + w_fe + w_pe !== 0) begin
      n_fail++; $display("FAIL glitch: got valid %0d fe %0d pe %0d want all 0", w_valid, w_fe, w_pe); end
    send_frame(8'h11, 1'b1, 1'b1, BIT_CLK);
    fork
      send_frame(8'h7E, 1'b1, 1'b1, BIT_CLK);
      begin
        @(posedge clk);
        repeat (BIT_CLK * 5 + BIT_CLK / 2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_run++; if ({rd_if.rdValid, rd_if.rdData, rd_if.fifoCount, frameError, parityError, overrun} !== '0) begin
          n_fail++; $display("FAIL midframe_reset: got valid %0b data %0h count %0d flags %b want all 0",
            rd_if.rdValid, rd_if.rdData, rd_if.fifoCount, {frameError, parityError, overrun}); end
      end
    join
    @(posedge clk); #1 rst = 1'b0;
    send_frame(8'h7E, 1'b1, 1'b1, BIT_CLK);
    repeat (3) @(negedge clk);
    n_run++; if (rd_if.fifoCount !== CW'(1) || rd_if.rdData !== 8'h7E) begin
      n_fail++; $display("FAIL post_reset_rx: got count %0d data %0h want 1/7e", rd_if.fifoCount, rd_if.rdData); end
    @(posedge clk); #1 rd_if.rdReady = 1'b1;
    @(posedge clk); #1 rd_if.rdReady = 1'b0;
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    rd_if.rdReady = 1'b0;
    fork
      send_frame(8'h03, 1'b1, 1'b1, BIT_CLK);
      watch(1900);
    join
    n_run++; if (w_pe !== 0 || rd_if.fifoCount !== CW'(1) || rd_if.rdData !== 8'h03) begin
      n_fail++; $display("FAIL par_good: got pe %0d count %0d data %0h want 0/1/03", w_pe, rd_if.fifoCount, rd_if.rdData); end
    @(posedge clk); #1 rd_if.rdReady = 1'b1;
    @(posedge clk); #1 rd_if.rdReady = 1'b0;
    fork
      send_frame(8'h03, 1'b0, 1'b1, BIT_CLK);
      watch(1900);
    join
    n_run++; if (w_pe !== 1) begin n_fail++; $display("FAIL par_bad_pulse: got %0d want 1", w_pe); end
    n_run++; if (w_valid !== 0 || w_fe !== 0 || rd_if.fifoCount !== CW'(0)) begin
      n_fail++; $display("FAIL par_bad_drop: got valid %0d fe %0d count %0d want 0/0/0", w_valid, w_fe, rd_if.fifoCount); end
  endtask
`endif

  initial begin
    rd_if.rdReady = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_error();
    test_glitch_and_reset();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    repeat (150_000) @(posedge clk);
    $display("FAIL watchdog: got no finish after 150000 cycles want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
